// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display scanners: anode idle pattern
// and an index-width helper usable in parameter expressions.
package display_pkg;

  localparam int MAX_DIG = 8;
  localparam logic [MAX_DIG-1:0] AN_OFF = 8'hFF;

  // Ceiling log2 with a floor of 1 so single-bit indices stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: step is high in the last cycle of each PRESCALE
// window, so the edge that ends it is the edge on which the counter wraps.
module tick_gen
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  localparam int CW = clog2(PRESCALE);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(PRESCALE - 1));
  assign step   = w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display with
// leading-zero blanking and frame-aligned (tear-free) word updates.
module display_scan
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int NDIG     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] num,
  input  logic              load,
  input  logic              blank_lz,
  output logic [3:0]        bcd_out,
  output logic [NDIG-1:0]   an_n,
  output logic [2:0]        digit_idx,
  output logic              tick
);

  localparam int IW = clog2(NDIG);
  localparam int DW = 4 * NDIG;

  logic            w_step;
  logic            w_last;
  logic            w_boundary;
  logic [IW-1:0]   w_idx_nxt;
  logic [DW-1:0]   w_disp_nxt;
  logic [3:0]      w_nib;
  logic            w_upper_zero;
  logic            w_blank;
  logic [NDIG-1:0] w_an;

  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   r_disp;
  logic            r_pending;
  logic [3:0]      r_bcd;
  logic [NDIG-1:0] r_an;
  logic            r_tick;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .step (w_step)
  );

  assign w_last     = (r_idx == IW'(NDIG - 1));
  assign w_boundary = w_step && w_last;
  assign w_idx_nxt  = w_last ? '0 : r_idx + IW'(1);

  // A load landing on the boundary edge bypasses the shadow and is shown at once.
  always_comb begin
    w_disp_nxt = r_disp;
    if (w_boundary && load) begin
      w_disp_nxt = num;
    end else if (w_boundary && r_pending) begin
      w_disp_nxt = r_shadow;
    end else begin
      w_disp_nxt = r_disp;
    end
  end

  // Nibble and blanking for the digit about to become active.
  always_comb begin
    w_nib        = 4'd0;
    w_upper_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if (IW'(j) == w_idx_nxt) begin
        w_nib = w_disp_nxt[4*j +: 4];
      end else begin
        w_nib = w_nib;
      end
      if ((j >= int'(w_idx_nxt)) && (w_disp_nxt[4*j +: 4] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end else begin
        w_upper_zero = w_upper_zero;
      end
    end
    w_blank = blank_lz && (w_idx_nxt != '0) && w_upper_zero;
    w_an    = AN_OFF[NDIG-1:0];
    if (!w_blank) begin
      w_an[w_idx_nxt] = 1'b0;
    end else begin
      w_an = AN_OFF[NDIG-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= IW'(NDIG - 1);
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
      r_bcd     <= 4'd0;
      r_an      <= AN_OFF[NDIG-1:0];
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_disp <= w_disp_nxt;
      if (w_step) begin
        r_idx <= w_idx_nxt;
        r_bcd <= w_nib;
        r_an  <= w_an;
      end else begin
        r_idx <= r_idx;
        r_bcd <= r_bcd;
        r_an  <= r_an;
      end
      if (load) begin
        r_shadow  <= num;
        r_pending <= !w_boundary;
      end else if (w_boundary) begin
        r_shadow  <= r_shadow;
        r_pending <= 1'b0;
      end else begin
        r_shadow  <= r_shadow;
        r_pending <= r_pending;
      end
    end
  end

  assign bcd_out   = r_bcd;
  assign an_n      = r_an;
  assign digit_idx = 3'(r_idx);
  assign tick      = r_tick;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (PRESCALE=4, NDIG=4): directed frame
// table, hand-written load/reset sequences and a randomized run vs a time-based model.
module tb_display_scan;

  localparam int P = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic [2:0]  digit_idx;
  logic        tick;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int          m_cyc = 0;
  logic [15:0] m_disp = 16'h0, m_shadow = 16'h0;
  logic        m_pending = 1'b0;
  logic [2:0]  m_idx = 3'd3;
  logic        m_tick = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [3:0]  m_bcd = 4'h0;

  display_scan #(.PRESCALE(P), .NDIG(N)) dut (
    .clk(clk), .rst(rst), .num(num), .load(load), .blank_lz(blank_lz),
    .bcd_out(bcd_out), .an_n(an_n), .digit_idx(digit_idx), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic        blz;
    logic [15:0] exp_an;   // slot s expectation in [4*s +: 4]
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
    m_idx = 3'd3; m_tick = 1'b0; m_an = 4'hF; m_bcd = 4'h0;
  endtask

  // Slot number follows from elapsed cycles since reset release.
  task automatic model_edge();
    bit stepnow, boundary, blanked;
    int nidx;
    if (rst) begin
      model_reset();
      return;
    end
    m_cyc++;
    stepnow  = (m_cyc % P) == 0;
    nidx     = stepnow ? ((m_cyc / P) - 1) % N : 0;
    boundary = stepnow && (nidx == 0);
    if (boundary) begin
      if (load) begin m_disp = num; m_shadow = num; end
      else if (m_pending) m_disp = m_shadow;
      m_pending = 1'b0;
    end else if (load) begin
      m_shadow = num; m_pending = 1'b1;
    end
    m_tick = stepnow;
    if (stepnow) begin
      m_idx   = 3'(nidx);
      m_bcd   = 4'((m_disp >> (4 * nidx)) & 16'hF);
      blanked = blank_lz && (nidx > 0) && ((m_disp >> (4 * nidx)) == 16'h0);
      m_an    = blanked ? 4'hF : ~(4'b0001 << nidx);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {20'h0, digit_idx, tick, an_n, bcd_out},
                   {20'h0, m_idx, m_tick, m_an, m_bcd});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_state", {20'h0, digit_idx, tick, an_n, bcd_out}, {20'h0, 3'd3, 1'b0, 4'hF, 4'h0});
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] e3;
    tbl[0] = '{16'h1234, 1'b0, 16'h7BDE, 16'h1234};
    tbl[1] = '{16'h0042, 1'b1, 16'hFFDE, 16'h0042};
    tbl[2] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000};
    tbl[3] = '{16'hABEF, 1'b0, 16'h7BDE, 16'hABEF};
    tbl[4] = '{16'h0900, 1'b1, 16'hFBDE, 16'h0900};
    tbl[5] = '{16'h1000, 1'b1, 16'h7BDE, 16'h1000};

    // Directed frames: load at cycle 1, dark until the first step edge.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      blank_lz = tbl[r].blz;
      for (int k = 1; k <= 16; k++) begin
        if (k == 1) begin load = 1'b1; num = tbl[r].num; end
        cyc();
        load = 1'b0;
        if (k < 4) check("dark", {28'h0, an_n}, {28'h0, 4'hF});
        else if (k % 4 == 0) begin
          check("tbl_an",  {28'h0, an_n},    {28'h0, tbl[r].exp_an[4*(k/4-1) +: 4]});
          check("tbl_bcd", {28'h0, bcd_out}, {28'h0, tbl[r].exp_bcd[4*(k/4-1) +: 4]});
          check("tbl_idx", {29'h0, digit_idx}, 32'(k/4 - 1));
        end
      end
    end

    // Mid-frame load while digit 1 shows: takes effect from the next digit 0.
    do_reset();
    blank_lz = 1'b0;
    e3 = 24'h004212;
    for (int k = 1; k <= 32; k++) begin
      if (k == 1) begin load = 1'b1; num = 16'h1234; end
      if (k == 10) begin load = 1'b1; num = 16'h0042; end
      cyc();
      load = 1'b0;
      if (k >= 12 && k % 4 == 0)
        check("midload", {28'h0, bcd_out}, {28'h0, e3[4*((k-12)/4) +: 4]});
    end

    // Reset while digit 2 is active with a load pending.
    do_reset();
    blank_lz = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 1) begin load = 1'b1; num = 16'h5678; end
      if (k == 13) begin load = 1'b1; num = 16'h9999; end
      cyc();
      load = 1'b0;
    end
    check("pre_rst_idx", {29'h0, digit_idx}, 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst", {20'h0, digit_idx, tick, an_n, bcd_out}, {20'h0, 3'd3, 1'b0, 4'hF, 4'h0});
    model_reset();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k % 4 == 0) check("no_stale", {28'h0, bcd_out}, 32'h0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      load = ($urandom % 8) == 0;
      for (int d = 0; d < 4; d++)
        num[4*d +: 4] = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
      if (($urandom % 50) == 0) blank_lz = ~blank_lz;
      rst = ($urandom % 400) == 0;
      cyc();
    end
    rst = 1'b0;
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
